// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RISC-V EX stage: ALU, branch resolve, EX/MEM register
//
// Optional macro: FORWARDING_EN
//   defined   : ForwardA_E/ForwardB_E select RD*_E, ResultW or ALU_ResultM
//   undefined : forwarding ports are ignored and the operands come straight from RD1_E/RD2_E
//
// Ports:
//   clk, reset            pipeline clock; asynchronous active-low reset
//   *E control/data       decode-stage outputs for the instruction in EX
//   ResultW               writeback result (forwarding source)
//   ForwardA_E/B_E        operand forward selects
//   PCSrcE, PCTargetE     combinational branch redirect to fetch
//   *M outputs            EX/MEM pipeline register, 1-cycle latency, no stall
module execute_cycle #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RegWriteE,
   input  logic                 ALUSrcE,
   input  logic                 MemWriteE,
   input  logic                 ResultSrcE,
   input  logic                 BranchE,
   input  logic [2:0]           ALUControlE,
   input  logic [XLEN-1:0]      RD1_E,
   input  logic [XLEN-1:0]      RD2_E,
   input  logic [XLEN-1:0]      Imm_ExtE,
   input  logic [REGADDR_W-1:0] RD_E,
   input  logic [XLEN-1:0]      PCE,
   input  logic [XLEN-1:0]      PCPlus4E,
   input  logic [XLEN-1:0]      ResultW,
   input  logic [1:0]           ForwardA_E,
   input  logic [1:0]           ForwardB_E,
   output logic                 PCSrcE,
   output logic [XLEN-1:0]      PCTargetE,
   output logic                 RegWriteM,
   output logic                 MemWriteM,
   output logic                 ResultSrcM,
   output logic [REGADDR_W-1:0] RD_M,
   output logic [XLEN-1:0]      PCPlus4M,
   output logic [XLEN-1:0]      WriteDataM,
   output logic [XLEN-1:0]      ALU_ResultM
);

   logic [XLEN-1:0]      src_a;
   logic [XLEN-1:0]      fwd_b;
   logic [XLEN-1:0]      src_b;
   logic [XLEN-1:0]      alu_result;
   logic                 zero_e;

   logic                 reg_write_d,   reg_write_q;
   logic                 mem_write_d,   mem_write_q;
   logic                 result_src_d,  result_src_q;
   logic [REGADDR_W-1:0] rd_d,          rd_q;
   logic [XLEN-1:0]      pc_plus4_d,    pc_plus4_q;
   logic [XLEN-1:0]      write_data_d,  write_data_q;
   logic [XLEN-1:0]      alu_result_d,  alu_result_q;

`ifdef FORWARDING_EN
   // Select 2'b11 is not a legal forward code; it falls back to the register file value.
   always_comb begin
      src_a = RD1_E;
      case (ForwardA_E)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = alu_result_q;
         default: src_a = RD1_E;
      endcase
   end

   always_comb begin
      fwd_b = RD2_E;
      case (ForwardB_E)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = alu_result_q;
         default: fwd_b = RD2_E;
      endcase
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};

   always_comb begin
      src_a = RD1_E;
      fwd_b = RD2_E;
   end
`endif

   always_comb begin
      src_b = ALUSrcE ? Imm_ExtE : fwd_b;
   end

   always_comb begin
      alu_result = '0;
      case (ALUControlE)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_result = '0;
      endcase
   end

   always_comb begin
      zero_e    = (alu_result == '0);
      PCSrcE    = BranchE & zero_e;
      PCTargetE = PCE + Imm_ExtE;
   end

   // Store data is the forwarded rs2 value, never the immediate.
   always_comb begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      rd_d         = RD_E;
      pc_plus4_d   = PCPlus4E;
      write_data_d = fwd_b;
      alu_result_d = alu_result;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= '0;
         pc_plus4_q   <= '0;
         write_data_q <= '0;
         alu_result_q <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         pc_plus4_q   <= pc_plus4_d;
         write_data_q <= write_data_d;
         alu_result_q <= alu_result_d;
      end
   end

   assign RegWriteM   = reg_write_q;
   assign MemWriteM   = mem_write_q;
   assign ResultSrcM  = result_src_q;
   assign RD_M        = rd_q;
   assign PCPlus4M    = pc_plus4_q;
   assign WriteDataM  = write_data_q;
   assign ALU_ResultM = alu_result_q;

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed self-checking bench for execute_cycle
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   execute_cycle #(.XLEN(32), .REGADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_ExtE(Imm_ExtE), .RD_E(RD_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
      .ALU_ResultM(ALU_ResultM)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_m_zero(input string tag);
      check({tag, "_regwrite"},  {31'b0, RegWriteM},  32'h0);
      check({tag, "_memwrite"},  {31'b0, MemWriteM},  32'h0);
      check({tag, "_resultsrc"}, {31'b0, ResultSrcM}, 32'h0);
      check({tag, "_rd"},        {27'b0, RD_M},       32'h0);
      check({tag, "_pcplus4"},   PCPlus4M,            32'h0);
      check({tag, "_wdata"},     WriteDataM,          32'h0);
      check({tag, "_alu"},       ALU_ResultM,         32'h0);
   endtask

   task automatic drive_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic src);
      ALUControlE = op;
      RD1_E       = a;
      RD2_E       = b;
      Imm_ExtE    = imm;
      ALUSrcE     = src;
   endtask

   initial begin
      reset = 1'b0;
      RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; BranchE = 1'b0; ALUSrcE = 1'b0;
      ALUControlE = 3'b000; RD1_E = 32'd2; RD2_E = 32'd3; Imm_ExtE = 32'h0;
      RD_E = 5'd9; PCE = 32'h0; PCPlus4E = 32'h44; ResultW = 32'h0;
      ForwardA_E = 2'b00; ForwardB_E = 2'b00;

      // Reset holds M outputs at zero across edges even with live inputs.
      #2;
      check_m_zero("reset_init");
      step();
      step();
      check_m_zero("reset_held");

      reset = 1'b1;
      step();
      check("add_basic", ALU_ResultM, 32'd5);
      check("add_regwrite", {31'b0, RegWriteM}, 32'h1);
      check("add_rd", {27'b0, RD_M}, 32'd9);
      check("add_wdata", WriteDataM, 32'd3);

      // Asynchronous reset mid-cycle clears the register without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      check_m_zero("reset_async");
      #1;
      reset = 1'b1;
      step();
      check("add_after_reset", ALU_ResultM, 32'd5);

      RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;
      drive_alu(3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
      step();
      check("add_wrap", ALU_ResultM, 32'h0);

      drive_alu(3'b001, 32'h0, 32'd1, 32'h0, 1'b0);
      step();
      check("sub_wrap", ALU_ResultM, 32'hFFFF_FFFF);

      drive_alu(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0);
      step();
      check("and", ALU_ResultM, 32'h00F0_1200);

      drive_alu(3'b011, 32'hF000_0001, 32'h0000_0F00, 32'h0, 1'b0);
      step();
      check("or", ALU_ResultM, 32'hF000_0F01);

      drive_alu(3'b101, 32'h8000_0000, 32'h0000_0055, 32'd1, 1'b1);
      step();
      check("slt_neg_lt_pos", ALU_ResultM, 32'd1);
      check("slt_wdata_rd2", WriteDataM, 32'h55);

      drive_alu(3'b101, 32'd1, 32'h0000_00AA, 32'h8000_0000, 1'b1);
      step();
      check("slt_pos_lt_neg", ALU_ResultM, 32'd0);
      check("slt_wdata_rd2_b", WriteDataM, 32'hAA);

      // Branch redirect is visible in the same cycle, before any edge.
      BranchE = 1'b1; PCE = 32'h100;
      drive_alu(3'b001, 32'd7, 32'd7, 32'hFFFF_FFF0, 1'b0);
      #1;
      check("beq_taken", {31'b0, PCSrcE}, 32'h1);
      check("beq_target", PCTargetE, 32'h0000_00F0);
      RD2_E = 32'd8;
      #1;
      check("beq_not_taken", {31'b0, PCSrcE}, 32'h0);
      check("beq_target_still", PCTargetE, 32'h0000_00F0);
      RD2_E = 32'd7; BranchE = 1'b0;
      #1;
      check("branch_gated", {31'b0, PCSrcE}, 32'h0);
      step();

      // Forwarding: first an add to load ALU_ResultM, then forward from M and W.
      drive_alu(3'b000, 32'd2, 32'd3, 32'h0, 1'b0);
      ForwardA_E = 2'b00; ForwardB_E = 2'b00; ResultW = 32'd9;
      step();
      check("fwd_seed", ALU_ResultM, 32'd5);
      ForwardA_E = 2'b10; ForwardB_E = 2'b01;
      step();
`ifdef FORWARDING_EN
      check("fwd_alu", ALU_ResultM, 32'd14);
      check("fwd_wdata", WriteDataM, 32'd9);
`else
      check("nofwd_alu", ALU_ResultM, 32'd5);
      check("nofwd_wdata", WriteDataM, 32'd3);
`endif
      // Select 11 behaves as 00; both muxes on the same source.
      ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'd20; RD2_E = 32'd4;
      step();
      check("fwd_11", ALU_ResultM, 32'd24);
      ForwardA_E = 2'b01; ForwardB_E = 2'b01; ResultW = 32'd100;
      step();
`ifdef FORWARDING_EN
      check("fwd_same_src", ALU_ResultM, 32'd200);
`else
      check("nofwd_same_src", ALU_ResultM, 32'd24);
`endif
      ForwardA_E = 2'b00; ForwardB_E = 2'b00;

      // Pass-through with an undefined ALU code.
      RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd17; PCPlus4E = 32'h204;
      drive_alu(3'b111, 32'd5, 32'd6, 32'h0, 1'b0);
      step();
      check("pt_regwrite",  {31'b0, RegWriteM},  32'h1);
      check("pt_memwrite",  {31'b0, MemWriteM},  32'h1);
      check("pt_resultsrc", {31'b0, ResultSrcM}, 32'h1);
      check("pt_rd",        {27'b0, RD_M},       32'd17);
      check("pt_pcplus4",   PCPlus4M,            32'h204);
      check("pt_alu_111",   ALU_ResultM,         32'h0);
      check("pt_wdata",     WriteDataM,          32'd6);

      drive_alu(3'b100, 32'd5, 32'd6, 32'h0, 1'b0);
      step();
      check("alu_100_zero", ALU_ResultM, 32'h0);
      drive_alu(3'b110, 32'd5, 32'd6, 32'h0, 1'b0);
      step();
      check("alu_110_zero", ALU_ResultM, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Sits directly downstream of the decode stage and consumes its E-side outputs.
- Performs the ALU operation, branch-target computation and taken-branch detection.
- Registers the results into the EX/MEM pipeline register, which feeds the memory stage.
- Branch redirect (PCSrcE, PCTargetE) is combinational back to fetch.

Parameters:
- XLEN, 32, datapath width.
- REGADDR_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- RegWriteE  in  1  register-write enable from decode
- ALUSrcE  in  1  0: SrcB = RD2 path; 1: SrcB = Imm_ExtE
- MemWriteE  in  1  store enable
- ResultSrcE  in  1  0: ALU result; 1: memory read data (used in the W stage)
- BranchE  in  1  beq instruction in EX
- ALUControlE  in  3  ALU operation select
- RD1_E  in  XLEN  rs1 data
- RD2_E  in  XLEN  rs2 data
- Imm_ExtE  in  XLEN  extended immediate
- RD_E  in  REGADDR_W  destination register
- PCE  in  XLEN  instruction PC
- PCPlus4E  in  XLEN  PC+4
- ResultW  in  XLEN  writeback result (forwarding source)
- ForwardA_E  in  2  rs1 forward select
- ForwardB_E  in  2  rs2 forward select
- PCSrcE  out  1  taken branch (combinational)
- PCTargetE  out  XLEN  branch target (combinational)
- RegWriteM  out  1  registered
- MemWriteM  out  1  registered
- ResultSrcM  out  1  registered
- RD_M  out  REGADDR_W  registered
- PCPlus4M  out  XLEN  registered
- WriteDataM  out  XLEN  registered store data
- ALU_ResultM  out  XLEN  registered ALU result

Behaviour:
- Reset: one clock (clk). Reset is asynchronous and active-low (reset). While reset=0, all M outputs are 0 immediately, without waiting for a clock edge.
- Reset mid-operation: asserting reset mid-stream discards the in-flight EX/MEM contents.
- Register update: outside reset, every M output captures its E-stage value on each rising clk edge. Latency is exactly 1 cycle. There is no stall or enable; the register updates every cycle.
- Forwarding mux (A, similarly B):
  - 00 → RD1_E / RD2_E
  - 01 → ResultW
  - 10 → ALU_ResultM (this block's own registered output)
  - 11 → treated as 00
- Operands: SrcA = forwarded A. SrcB = ALUSrcE ? Imm_ExtE : forwarded B.
- ALUControlE encoding (results mod 2^XLEN, wrap-around silent, no overflow output):
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt (signed; result is 1 or 0, zero-extended)
  - any other code → result 0
- Zero flag: ZeroE = (ALU result == 0). Flags are combinational and internal.
- Branch outputs:
  - PCSrcE = BranchE & ZeroE.
  - PCTargetE = PCE + Imm_ExtE (mod 2^XLEN), driven regardless of BranchE.
- Store data: WriteDataM captures the forwarded B value, never Imm_ExtE, even when ALUSrcE=1.
- Control pass-through: RegWriteE, MemWriteE, ResultSrcE, RD_E and PCPlus4E pass unmodified into the M register.
- Simultaneous forwarding: ForwardA_E and ForwardB_E may select the same source in the same cycle; both muxes resolve independently.
- Flush responsibility: a taken branch does not flush this stage's own register. Flushing younger stages is the hazard unit's job.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: forwarding muxes behave as specified above.
- Undefined:
  - ForwardA_E, ForwardB_E and ResultW remain ports but are ignored.
  - SrcA = RD1_E; the B path uses RD2_E directly.
  - All other behaviour is identical.

Test Plan:
- Reset: reset=0 asynchronously mid-cycle with non-zero state → all M outputs 0 before the next clk edge. Release reset, then drive an add → results appear 1 edge later.
- Add/sub wrap: RD1_E=32'hFFFFFFFF, RD2_E=1, ALUSrcE=0, ALUControlE=000 → ALU_ResultM=0 after 1 edge. Then 001 with RD1_E=0, RD2_E=1 → 32'hFFFFFFFF.
- slt signed: RD1_E=32'h80000000, Imm_ExtE=1, ALUSrcE=1, ALUControlE=101 → ALU_ResultM=1. Swap operands → 0. WriteDataM=RD2_E in both cases.
- Branch: BranchE=1, RD1_E=RD2_E=7, ALUControlE=001, PCE=32'h100, Imm_ExtE=32'hFFFFFFF0 → PCSrcE=1, PCTargetE=32'hF0 in the same cycle. RD2_E=8 → PCSrcE=0.
- Forwarding (FORWARDING_EN defined):
  - Cycle n: add RD1_E=2, RD2_E=3 → ALU_ResultM=5.
  - Cycle n+1: ForwardA_E=10, ForwardB_E=01, ResultW=9, add → ALU_ResultM=14.
  - With the macro undefined, the same stimulus gives RD1_E+RD2_E.
- Pass-through: RegWriteE=1, MemWriteE=1, ResultSrcE=1, RD_E=5'd17, PCPlus4E=32'h204 → identical values on the M outputs after 1 edge, unchanged by ALUControlE=111 (ALU_ResultM=0).
